// File: rtl/mpi_pkg.sv
// rtl/mpi_pkg.sv - shared types and default widths for the MPI credit sender
package mpi_pkg;

  localparam int MPI_DATA_W     = 64;
  localparam int MPI_RANK_W     = 32;
  localparam int MPI_FIFO_DEPTH = 4;
  localparam int MPI_CREDITS    = 4;

  // Buffered flit at the default widths: destination rank plus payload
  typedef struct packed {
    logic [MPI_RANK_W-1:0] dest;
    logic [MPI_DATA_W-1:0] data;
  } mpi_flit_t;

  typedef enum logic {
    TX_EMPTY,
    TX_LOADED
  } mpi_tx_state_e;

endpackage

// File: rtl/mpi_sync_fifo.sv
// rtl/mpi_sync_fifo.sv - single-clock FIFO with exact full/empty flags
module mpi_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     head_o
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates the full case from the empty case
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  T            mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; callers never push at full or pop at empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers, cleared on reset so the FIFO reads as empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mpi_credit_sender.sv
// rtl/mpi_credit_sender.sv - credit-gated MPI flit transmitter (optional tx_seq via MPI_SENDER_SEQ_EN)
module mpi_credit_sender
  import mpi_pkg::*;
#(
  parameter int DATA_W     = MPI_DATA_W,
  parameter int RANK_W     = MPI_RANK_W,
  parameter int FIFO_DEPTH = MPI_FIFO_DEPTH,
  parameter int CREDITS    = MPI_CREDITS,
  localparam int CNT_W     = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RANK_W-1:0] rnk,
  input  logic [RANK_W-1:0] dest,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_yumi,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [RANK_W-1:0] tx_dest,
  output logic [RANK_W-1:0] tx_origin,
  input  logic              credit_return,
  output logic [CNT_W-1:0]  credit_cnt,
  output logic              err_credit_ovf
`ifdef MPI_SENDER_SEQ_EN
  ,
  output logic [15:0]       tx_seq
`endif
);

  localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(CREDITS);

  typedef struct packed {
    logic [RANK_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } flit_t;

  flit_t         fifo_wdata;
  flit_t         fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          load;

  mpi_tx_state_e state_q, state_d;
  logic [DATA_W-1:0] tx_data_q;
  logic [RANK_W-1:0] tx_dest_q;
  logic [RANK_W-1:0] tx_origin_q;
  logic [CNT_W-1:0]  credit_q, credit_d;
  logic              err_q, err_d;

  // Producer handshake uses only registered FIFO state, so no push ever lands at full
  assign in_yumi    = in_valid & ~fifo_full & ~rst;
  assign fifo_wdata = '{dest: dest, data: in_data};

  mpi_sync_fifo #(
    .T     (flit_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (in_yumi),
    .wdata_i (fifo_wdata),
    .pop_i   (load),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Output FSM: load when the register is free or draining this cycle and a credit is in hand
  always_comb begin
    state_d  = state_q;
    tx_valid = (state_q == TX_LOADED);
    load     = ~fifo_empty && (credit_q != '0) &&
               ((state_q == TX_EMPTY) || tx_ready);
    if (load) begin
      state_d = TX_LOADED;
    end else if ((state_q == TX_LOADED) && tx_ready) begin
      state_d = TX_EMPTY;
    end
  end

  // Output FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= TX_EMPTY;
    else     state_q <= state_d;
  end

  // Output payload register; holds steady while the bridge stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q   <= '0;
      tx_dest_q   <= '0;
      tx_origin_q <= '0;
    end else if (load) begin
      tx_data_q   <= fifo_head.data;
      tx_dest_q   <= fifo_head.dest;
      tx_origin_q <= rnk;
    end
  end

  // Credit bookkeeping: reserve on load, replenish on return, saturate and flag overflow
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    case ({load, credit_return})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CREDITS_C) err_d = 1'b1;
        else                       credit_d = credit_q + 1'b1;
      end
      default: credit_d = credit_q;
    endcase
  end

  // Credit counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CREDITS_C;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_dest        = tx_dest_q;
  assign tx_origin      = tx_origin_q;
  assign credit_cnt     = credit_q;
  assign err_credit_ovf = err_q;

`ifdef MPI_SENDER_SEQ_EN
  logic [15:0] seq_cnt_q;
  logic [15:0] tx_seq_q;

  // Sequence tag captured with each load; counter wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt_q <= '0;
      tx_seq_q  <= '0;
    end else if (load) begin
      tx_seq_q  <= seq_cnt_q;
      seq_cnt_q <= seq_cnt_q + 16'd1;
    end
  end

  assign tx_seq = tx_seq_q;
`endif

endmodule
